// File: rtl/book_snapshot_tx_pkg.sv
// Shared constants, state encoding and byte helpers for the order-book snapshot
// transmitter.
package book_snapshot_tx_pkg;

  localparam logic [7:0] SNAP_MSG_TYPE = 8'h53;

  typedef enum logic [1:0] {
    SNAP_IDLE   = 2'd0,
    SNAP_HDR    = 2'd1,
    SNAP_LEVELS = 2'd2
  } snap_state_t;

  function automatic int unsigned snapFrameLen(input int unsigned depth);
    return 32'd6 + (32'd8 * depth);
  endfunction

  // Byte sel of a 32-bit word in big-endian order (sel 0 is the MSB).
  function automatic logic [7:0] snapBeByte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] result;
    case (sel)
      2'd0:    result = word[31:24];
      2'd1:    result = word[23:16];
      2'd2:    result = word[15:8];
      2'd3:    result = word[7:0];
      default: result = 8'h00;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/book_snapshot_tx.sv
// Captures the order book on update and streams it as a framed big-endian byte
// stream; updates arriving mid-frame are merged into one follow-up frame.
module book_snapshot_tx
  import book_snapshot_tx_pkg::*;
#(
  parameter int unsigned ORDER_BOOK_DEPTH = 8
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic                          bookUpdatedIn,
  input  logic [ORDER_BOOK_DEPTH*32-1:0] priceLevelsIn,
  input  logic [ORDER_BOOK_DEPTH*32-1:0] quantLevelsIn,
  output logic [7:0]                    txDataOut,
  output logic                          txValidOut,
  output logic                          txLastOut,
  input  logic                          txReadyIn,
  output logic                          busyOut,
  output logic [31:0]                   seqNumOut,
  output logic [15:0]                   coalescedCntOut
);

  localparam int unsigned FRAME_LEN  = snapFrameLen(ORDER_BOOK_DEPTH);
  localparam logic [15:0] LAST_IDX   = 16'(FRAME_LEN - 32'd1);
  localparam logic [7:0]  DEPTH_BYTE = 8'(ORDER_BOOK_DEPTH);

  snap_state_t                    stateR;
  logic [15:0]                    byteIdxR;
  logic                           pendingR;
  logic [ORDER_BOOK_DEPTH*32-1:0] priceShadowR;
  logic [ORDER_BOOK_DEPTH*32-1:0] quantShadowR;
  logic [31:0]                    seqShadowR;

  logic        acceptS;
  logic        lastAcceptS;
  logic        captureS;
  logic [31:0] captureSeqS;
  logic [15:0] nextIdxS;
  logic [15:0] levelOffS;
  logic [15:0] levelS;
  logic [31:0] priceWordS;
  logic [31:0] quantWordS;
  logic [7:0]  nextByteS;

  // Handshake decode and capture decision; a back-to-back capture carries the
  // sequence number that is about to be committed.
  always_comb begin
    acceptS     = txValidOut & txReadyIn;
    lastAcceptS = acceptS & txLastOut & (stateR == SNAP_LEVELS);
    captureS    = 1'b0;
    captureSeqS = seqNumOut;
    if (stateR == SNAP_IDLE) begin
      captureS = bookUpdatedIn;
    end else if (lastAcceptS) begin
      captureS    = pendingR | bookUpdatedIn;
      captureSeqS = seqNumOut + 32'd1;
    end else begin
      captureS = 1'b0;
    end
  end

  // Next-byte mux over the shadow registers: level = (idx-6)/8, byte = (idx-6)%8.
  always_comb begin
    nextIdxS   = byteIdxR + 16'd1;
    levelOffS  = nextIdxS - 16'd6;
    levelS     = {3'b000, levelOffS[15:3]};
    priceWordS = 32'd0;
    quantWordS = 32'd0;
    for (int k = 0; k < ORDER_BOOK_DEPTH; k++) begin
      if (levelS == 16'(k)) begin
        priceWordS = priceShadowR[k*32 +: 32];
        quantWordS = quantShadowR[k*32 +: 32];
      end else begin
        priceWordS = priceWordS;
        quantWordS = quantWordS;
      end
    end
    if (nextIdxS < 16'd5) begin
      nextByteS = snapBeByte(seqShadowR, 2'(nextIdxS - 16'd1));
    end else if (nextIdxS == 16'd5) begin
      nextByteS = DEPTH_BYTE;
    end else if (!levelOffS[2]) begin
      nextByteS = snapBeByte(priceWordS, levelOffS[1:0]);
    end else begin
      nextByteS = snapBeByte(quantWordS, levelOffS[1:0]);
    end
  end

  // Shadow copy of the book; deliberately not reset so an abort leaves it untouched.
  always_ff @(posedge clkIn) begin
    if (captureS) begin
      priceShadowR <= priceLevelsIn;
      quantShadowR <= quantLevelsIn;
      seqShadowR   <= captureSeqS;
    end
  end

  // Frame sequencer with registered stream outputs.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      stateR     <= SNAP_IDLE;
      byteIdxR   <= 16'd0;
      txDataOut  <= 8'h00;
      txValidOut <= 1'b0;
      txLastOut  <= 1'b0;
      busyOut    <= 1'b0;
    end else if (captureS) begin
      stateR     <= SNAP_HDR;
      byteIdxR   <= 16'd0;
      txDataOut  <= SNAP_MSG_TYPE;
      txValidOut <= 1'b1;
      txLastOut  <= 1'b0;
      busyOut    <= 1'b1;
    end else begin
      case (stateR)
        SNAP_IDLE: begin
          txValidOut <= 1'b0;
          busyOut    <= 1'b0;
        end
        SNAP_HDR, SNAP_LEVELS: begin
          if (lastAcceptS) begin
            stateR     <= SNAP_IDLE;
            byteIdxR   <= 16'd0;
            txDataOut  <= 8'h00;
            txValidOut <= 1'b0;
            txLastOut  <= 1'b0;
            busyOut    <= 1'b0;
          end else if (acceptS) begin
            byteIdxR  <= nextIdxS;
            txDataOut <= nextByteS;
            txLastOut <= (nextIdxS == LAST_IDX);
            if ((stateR == SNAP_HDR) && (byteIdxR == 16'd5)) begin
              stateR <= SNAP_LEVELS;
            end
          end
        end
        default: begin
          stateR     <= SNAP_IDLE;
          byteIdxR   <= 16'd0;
          txDataOut  <= 8'h00;
          txValidOut <= 1'b0;
          txLastOut  <= 1'b0;
          busyOut    <= 1'b0;
        end
      endcase
    end
  end

  // Frame counter and coalescing of updates that arrive while a frame is in flight.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      seqNumOut       <= 32'd0;
      coalescedCntOut <= 16'd0;
      pendingR        <= 1'b0;
    end else begin
      if (lastAcceptS) begin
        seqNumOut <= seqNumOut + 32'd1;
      end
      if (captureS) begin
        pendingR <= 1'b0;
      end else if (bookUpdatedIn && (stateR != SNAP_IDLE)) begin
        pendingR <= 1'b1;
        if (pendingR && (coalescedCntOut != 16'hFFFF)) begin
          coalescedCntOut <= coalescedCntOut + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_book_snapshot_tx.sv
// Randomized self-checking bench for book_snapshot_tx (DEPTH=2) against a
// frame-level reference model plus literal expectations for directed cases.
module tb_book_snapshot_tx;
  import book_snapshot_tx_pkg::*;

  localparam int DEPTH     = 2;
  localparam int FRAME_LEN = 6 + 8 * DEPTH;

  logic                  clkIn = 1'b0;
  logic                  rstIn = 1'b1;
  logic                  bookUpdatedIn = 1'b0;
  logic                  txReadyIn = 1'b0;
  logic [DEPTH*32-1:0]   priceLevelsIn = '0;
  logic [DEPTH*32-1:0]   quantLevelsIn = '0;
  logic [7:0]            txDataOut;
  logic                  txValidOut;
  logic                  txLastOut;
  logic                  busyOut;
  logic [31:0]           seqNumOut;
  logic [15:0]           coalescedCntOut;

  int checks = 0;
  int failures = 0;

  book_snapshot_tx #(.ORDER_BOOK_DEPTH(DEPTH)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .bookUpdatedIn(bookUpdatedIn),
    .priceLevelsIn(priceLevelsIn), .quantLevelsIn(quantLevelsIn),
    .txDataOut(txDataOut), .txValidOut(txValidOut), .txLastOut(txLastOut),
    .txReadyIn(txReadyIn), .busyOut(busyOut), .seqNumOut(seqNumOut),
    .coalescedCntOut(coalescedCntOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  bit          mBusy = 1'b0;
  bit          mPending = 1'b0;
  int          mPos = 0;
  logic [31:0] mSeq = 32'd0;
  logic [15:0] mCoal = 16'd0;
  logic [7:0]  mFrame [FRAME_LEN];
  bit          preloadReq = 1'b0;
  logic [7:0]  rxQ [$];
  bit          rxLastQ [$];

  task automatic modelStart();
    logic [31:0] p;
    logic [31:0] q;
    mFrame[0] = 8'h53;
    mFrame[1] = mSeq[31:24];
    mFrame[2] = mSeq[23:16];
    mFrame[3] = mSeq[15:8];
    mFrame[4] = mSeq[7:0];
    mFrame[5] = 8'(DEPTH);
    for (int l = 0; l < DEPTH; l++) begin
      p = priceLevelsIn[32*l +: 32];
      q = quantLevelsIn[32*l +: 32];
      for (int b = 0; b < 4; b++) begin
        mFrame[6 + 8*l + b]  = p[31 - 8*b -: 8];
        mFrame[10 + 8*l + b] = q[31 - 8*b -: 8];
      end
    end
    mPos  = 0;
    mBusy = 1'b1;
  endtask

  initial begin
    bit         presValid;
    logic [7:0] presData;
    bit         presLast;
    bit         wasRst;
    bit         isLast;
    presValid = 1'b0;
    presData  = 8'h00;
    presLast  = 1'b0;
    forever begin
      @(posedge clkIn);
      wasRst = rstIn;
      if (!rstIn && presValid && txReadyIn) begin
        rxQ.push_back(presData);
        rxLastQ.push_back(presLast);
      end
      if (preloadReq) mSeq = 32'hFFFF_FFFF;
      if (rstIn) begin
        mBusy = 1'b0; mPending = 1'b0; mSeq = 32'd0; mCoal = 16'd0; mPos = 0;
      end else if (!mBusy) begin
        if (bookUpdatedIn) modelStart();
      end else begin
        isLast = txReadyIn && (mPos == FRAME_LEN - 1);
        if (bookUpdatedIn && !isLast) begin
          if (mPending && mCoal != 16'hFFFF) mCoal = mCoal + 16'd1;
          mPending = 1'b1;
        end
        if (isLast) begin
          mSeq = mSeq + 32'd1;
          if (mPending || bookUpdatedIn) begin
            mPending = 1'b0;
            modelStart();
          end else begin
            mBusy = 1'b0;
          end
        end else if (txReadyIn) begin
          mPos = mPos + 1;
        end
      end
      #1;
      checkEq("valid", txValidOut, mBusy);
      checkEq("busy", busyOut, mBusy);
      checkEq("seq", seqNumOut, mSeq);
      checkEq("coal", coalescedCntOut, mCoal);
      if (mBusy) begin
        checkEq("data", txDataOut, mFrame[mPos]);
        checkEq("last", txLastOut, (mPos == FRAME_LEN - 1));
      end else begin
        checkEq("last_idle", txLastOut, 1'b0);
      end
      if (wasRst) checkEq("rst_data", txDataOut, 8'h00);
      presValid = txValidOut;
      presData  = txDataOut;
      presLast  = txLastOut;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clkIn);
  endtask

  task automatic doReset();
    rstIn = 1'b1;
    bookUpdatedIn = 1'b0;
    step();
    rstIn = 1'b0;
  endtask

  task automatic pulseOnce();
    bookUpdatedIn = 1'b1;
    step();
    bookUpdatedIn = 1'b0;
  endtask

  task automatic setBook(input logic [31:0] p1, input logic [31:0] q1,
                         input logic [31:0] p2, input logic [31:0] q2);
    priceLevelsIn = {p2, p1};
    quantLevelsIn = {q2, q1};
  endtask

  task automatic waitIdle(input string tag, input int bound);
    int n;
    n = 0;
    while (mBusy && n < bound) begin
      step();
      n++;
    end
    checkEq({tag, "_timeout"}, mBusy, 1'b0);
  endtask

  logic [7:0] ref1 [FRAME_LEN] = '{8'h53, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                                   8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h0A,
                                   8'h00, 8'h00, 8'h00, 8'h63, 8'h00, 8'h00, 8'h00, 8'h05};

  task automatic checkRef1(input string tag, input int base);
    checkEq({tag, "_len"}, rxQ.size() - base, FRAME_LEN);
    if (rxQ.size() >= base + FRAME_LEN) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        checkEq({tag, "_byte"}, rxQ[base + i], ref1[i]);
        checkEq({tag, "_lastflag"}, rxLastQ[base + i], (i == FRAME_LEN - 1));
      end
    end
  endtask

  initial begin
    int base;
    int n;
    int lastCnt;
    logic [31:0] cP1;
    logic [31:0] expSeq;

    step();
    step();
    rstIn = 1'b0;

    // 1: single frame, ready held high
    doReset();
    setBook(32'h64, 32'h0A, 32'h63, 32'h05);
    txReadyIn = 1'b1;
    base = rxQ.size();
    pulseOnce();
    waitIdle("s1", 100);
    checkRef1("s1", base);
    checkEq("s1_seqnum", seqNumOut, 32'd1);

    // 2: backpressure and inputs changing mid-frame
    doReset();
    setBook(32'h64, 32'h0A, 32'h63, 32'h05);
    txReadyIn = 1'b1;
    base = rxQ.size();
    pulseOnce();
    n = 0;
    while (mBusy && n < 400) begin
      case (n)
        0:       txReadyIn = 1'b0;
        1:       txReadyIn = 1'b0;
        2:       txReadyIn = 1'b1;
        default: txReadyIn = 1'($urandom_range(0, 1));
      endcase
      priceLevelsIn = {$urandom, $urandom};
      quantLevelsIn = {$urandom, $urandom};
      step();
      n++;
    end
    checkEq("s2_timeout", mBusy, 1'b0);
    checkRef1("s2", base);

    // 3: three updates during frame 0 coalesce into one follow-up frame
    doReset();
    setBook(32'h64, 32'h0A, 32'h63, 32'h05);
    txReadyIn = 1'b1;
    base = rxQ.size();
    pulseOnce();
    step(); step();
    setBook($urandom, $urandom, $urandom, $urandom);
    pulseOnce();
    step(); step();
    pulseOnce();
    step();
    cP1 = $urandom;
    setBook(cP1, $urandom, $urandom, $urandom);
    pulseOnce();
    waitIdle("s3", 200);
    checkEq("s3_coal", coalescedCntOut, 16'd2);
    checkEq("s3_len", rxQ.size() - base, 2 * FRAME_LEN);
    checkEq("s3_seqnum", seqNumOut, 32'd2);
    if (rxQ.size() >= base + 2 * FRAME_LEN) begin
      checkEq("s3_type", rxQ[base + 22], 8'h53);
      expSeq = 32'd1;
      for (int b = 0; b < 4; b++) begin
        checkEq("s3_seqfield", rxQ[base + 23 + b], expSeq[31 - 8*b -: 8]);
        checkEq("s3_price1", rxQ[base + 28 + b], cP1[31 - 8*b -: 8]);
      end
    end

    // 4: update exactly in the last-byte-accept cycle
    doReset();
    setBook(32'h64, 32'h0A, 32'h63, 32'h05);
    txReadyIn = 1'b1;
    base = rxQ.size();
    pulseOnce();
    n = 0;
    while (!(mBusy && mPos == FRAME_LEN - 1) && n < 100) begin
      step();
      n++;
    end
    checkEq("s4_reach_last", txLastOut, 1'b1);
    setBook($urandom, $urandom, $urandom, $urandom);
    pulseOnce();
    checkEq("s4_valid", txValidOut, 1'b1);
    checkEq("s4_byte0", txDataOut, 8'h53);
    checkEq("s4_seqnum", seqNumOut, 32'd1);
    waitIdle("s4", 100);
    checkEq("s4_len", rxQ.size() - base, 2 * FRAME_LEN);
    checkEq("s4_coal", coalescedCntOut, 16'd0);

    // 5: reset at byte 10 aborts without a last byte
    doReset();
    setBook(32'h64, 32'h0A, 32'h63, 32'h05);
    txReadyIn = 1'b1;
    base = rxQ.size();
    pulseOnce();
    n = 0;
    while (!(mBusy && mPos == 10) && n < 100) begin
      step();
      n++;
    end
    rstIn = 1'b1;
    step();
    rstIn = 1'b0;
    checkEq("s5_valid", txValidOut, 1'b0);
    checkEq("s5_seqnum", seqNumOut, 32'd0);
    checkEq("s5_aborted_len", rxQ.size() - base, 10);
    lastCnt = 0;
    for (int i = base; i < rxQ.size(); i++) lastCnt += int'(rxLastQ[i]);
    checkEq("s5_nolast", lastCnt, 0);
    base = rxQ.size();
    pulseOnce();
    waitIdle("s5", 100);
    checkRef1("s5", base);

    // 6: sequence number preloaded to all-ones wraps after the frame
    force dut.seqNumOut = 32'hFFFF_FFFF;
    preloadReq = 1'b1;
    step();
    release dut.seqNumOut;
    preloadReq = 1'b0;
    base = rxQ.size();
    pulseOnce();
    waitIdle("s6", 100);
    checkEq("s6_len", rxQ.size() - base, FRAME_LEN);
    if (rxQ.size() >= base + FRAME_LEN) begin
      for (int b = 1; b <= 4; b++) checkEq("s6_seqfield", rxQ[base + b], 8'hFF);
    end
    checkEq("s6_wrap", seqNumOut, 32'd0);

    // random soak against the model
    for (int c = 0; c < 1500; c++) begin
      bookUpdatedIn = ($urandom_range(0, 11) == 0);
      txReadyIn     = ($urandom_range(0, 3) != 0);
      priceLevelsIn = {$urandom, $urandom};
      quantLevelsIn = {$urandom, $urandom};
      step();
    end
    bookUpdatedIn = 1'b0;
    txReadyIn = 1'b1;
    waitIdle("soak", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
